regfile_sb: RTL and testbench

// Integer register file and scoreboard that sits at the receiving end of the writeback port.

---
 rtl/core_pkg.sv | 36 +++
 rtl/sb_counter.sv | 41 ++++
 rtl/regfile_sb.sv | 198 +++++++++++++++++++
 tb/tb_regfile_sb.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : core_pkg                                                         |
// | Purpose : Shared integer-core constants, ABI register indices and the      |
// |           ECALL snapshot state encoding.                                   |
// | Contents: REGBITS, XLEN, NUM_ARGS, A0..A7, ecall_state_t                   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package core_pkg;

  // Architectural register file geometry.
  localparam int REGBITS  = 5;
  localparam int XLEN     = 64;

  // Number of ECALL argument registers (a0..a7).
  localparam int NUM_ARGS = 8;

  // ABI indices of the argument registers.
  localparam int A0 = 10;
  localparam int A1 = 11;
  localparam int A2 = 12;
  localparam int A3 = 13;
  localparam int A4 = 14;
  localparam int A5 = 15;
  localparam int A6 = 16;
  localparam int A7 = 17;

  // ECALL snapshot sequencer states.
  typedef enum logic [1:0] {
    ECS_IDLE  = 2'd0,
    ECS_DRAIN = 2'd1,
    ECS_SNAP  = 2'd2
  } ecall_state_t;

endpackage
`default_nettype wire

// File: rtl/sb_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sb_counter                                                       |
// | Purpose : Per-register pending-write counter. Saturating up/down counter   |
// |           with synchronous clear; simultaneous inc and dec leave it alone. |
// | Ports   : clk, rst   - clock, synchronous active-high reset                |
// |           clr        - synchronous clear (pipeline flush)                  |
// |           inc, dec   - count up (accepted issue) / down (writeback)        |
// |           cnt        - current count                                       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module sb_counter #(
  parameter int CNTW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc,
  input  logic            dec,
  output logic [CNTW-1:0] cnt
);

  localparam logic [CNTW-1:0] C_MAX = '1;

  logic [CNTW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (inc && !dec && (r_cnt != C_MAX)) begin
      r_cnt <= r_cnt + CNTW'(1);
    end else if (dec && !inc && (r_cnt != '0)) begin
      // A writeback with nothing pending (e.g. after a flush) is harmless.
      r_cnt <= r_cnt - CNTW'(1);
    end
  end

  assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : regfile_sb                                                       |
// | Purpose : Integer register file plus issue scoreboard. Issue reads sources |
// |           and marks pending destinations; writeback retires results into   |
// |           the array (wb_rd==0 is a bubble). Also produces a consistent     |
// |           snapshot of a0..a7 for ECALL handling.                           |
// | Ports   : clk, rst                 - clock, sync active-high reset         |
// |           rs1_addr/rs2_addr        - read indices                          |
// |           rs1_data/rs2_data        - read data, writeback-bypassed         |
// |           rs_hazard                - a source has an unretired write       |
// |           issue_valid/issue_rd     - issuing instruction and destination   |
// |           issue_ok                 - issue accepted                        |
// |           wb_rd/wb_data            - writeback destination and data        |
// |           flush                    - drop all pending writes               |
// |           ecall_req                - request an a0..a7 snapshot            |
// |           ecall_ready/ecall_args   - snapshot-valid pulse and held values  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module regfile_sb #(
  parameter int REGBITS = core_pkg::REGBITS,
  parameter int XLEN    = core_pkg::XLEN,
  parameter int CNTW    = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [REGBITS-1:0]                     rs1_addr,
  input  logic [REGBITS-1:0]                     rs2_addr,
  output logic [XLEN-1:0]                        rs1_data,
  output logic [XLEN-1:0]                        rs2_data,
  output logic                                   rs_hazard,
  input  logic                                   issue_valid,
  input  logic [REGBITS-1:0]                     issue_rd,
  output logic                                   issue_ok,
  input  logic [REGBITS-1:0]                     wb_rd,
  input  logic [XLEN-1:0]                        wb_data,
  input  logic                                   flush,
  input  logic                                   ecall_req,
  output logic                                   ecall_ready,
  output logic [core_pkg::NUM_ARGS-1:0][XLEN-1:0] ecall_args
);

  import core_pkg::*;

  localparam int              NREGS     = 2 ** REGBITS;
  localparam logic [CNTW-1:0] C_CNT_MAX = '1;

  // --------------------------------------------------------------------------
  // Register array. Entry 0 is held at zero and never written.
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] r_regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wb_rd != '0) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  // --------------------------------------------------------------------------
  // Read ports: x0 is hard zero; a same-cycle writeback is forwarded so the
  // consumer never sees the stale array value.
  // --------------------------------------------------------------------------
  always_comb begin
    rs1_data = r_regs[rs1_addr];
    if (rs1_addr == '0) begin
      rs1_data = '0;
    end else if (wb_rd == rs1_addr) begin
      rs1_data = wb_data;
    end
  end

  always_comb begin
    rs2_data = r_regs[rs2_addr];
    if (rs2_addr == '0) begin
      rs2_data = '0;
    end else if (wb_rd == rs2_addr) begin
      rs2_data = wb_data;
    end
  end

  // --------------------------------------------------------------------------
  // Pending-write counters, one per architectural register except x0.
  // --------------------------------------------------------------------------
  logic [CNTW-1:0]  w_cnt  [NREGS];
  logic [NREGS-1:0] w_busy;

  assign w_cnt[0] = '0;

  generate
    for (genvar r = 1; r < NREGS; r++) begin : g_cnt
      logic w_inc;
      logic w_dec;

      assign w_inc = issue_ok && (issue_rd == REGBITS'(r));
      assign w_dec = (wb_rd == REGBITS'(r));

      sb_counter #(
        .CNTW (CNTW)
      ) u_sb_counter (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (w_inc),
        .dec (w_dec),
        .cnt (w_cnt[r])
      );
    end
  endgenerate

  // A register whose only outstanding write retires this cycle is not busy:
  // the bypass delivers that value to the reader.
  generate
    for (genvar r = 0; r < NREGS; r++) begin : g_busy
      assign w_busy[r] = (w_cnt[r] > ((wb_rd == REGBITS'(r)) ? CNTW'(1) : CNTW'(0)));
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Hazard and issue acceptance. A saturated destination counter blocks issue
  // unless a writeback to the same register frees a slot in this cycle.
  // --------------------------------------------------------------------------
  logic w_rd_full;

  assign rs_hazard = w_busy[rs1_addr] | w_busy[rs2_addr];
  assign w_rd_full = (issue_rd != '0) && (w_cnt[issue_rd] == C_CNT_MAX) && (wb_rd != issue_rd);
  assign issue_ok  = issue_valid && !rs_hazard && !w_rd_full;

  // --------------------------------------------------------------------------
  // ECALL snapshot sequencer.
  // --------------------------------------------------------------------------
  ecall_state_t                          r_state;
  ecall_state_t                          w_state_nxt;
  logic                                  w_capture;
  logic                                  w_drain_done;
  logic [NUM_ARGS-1:0][XLEN-1:0]         w_snap;
  logic [NUM_ARGS-1:0][XLEN-1:0]         r_args;

  // Drained once no argument register is still busy, counting a same-cycle
  // writeback as already retired.
  assign w_drain_done = ~|w_busy[A7:A0];

  // Snapshot values see the same bypass as the read ports.
  generate
    for (genvar i = 0; i < NUM_ARGS; i++) begin : g_snap
      assign w_snap[i] = (wb_rd == REGBITS'(A0 + i)) ? wb_data : r_regs[A0 + i];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ECS_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    ecall_ready = 1'b0;
    case (r_state)
      ECS_IDLE: begin
        if (ecall_req) begin
          w_state_nxt = ECS_DRAIN;
        end
      end
      ECS_DRAIN: begin
        if (w_drain_done) begin
          w_capture   = 1'b1;
          w_state_nxt = ECS_SNAP;
        end
      end
      ECS_SNAP: begin
        ecall_ready = 1'b1;
        w_state_nxt = ECS_IDLE;
      end
      default: begin
        w_state_nxt = ECS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_args <= '0;
    end else if (w_capture) begin
      r_args <= w_snap;
    end
  end

  assign ecall_args = r_args;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_regfile_sb                                                    |
// | Purpose : Self-checking bench for regfile_sb. Expected values are queued   |
// |           when stimulus is applied and popped when the DUT is sampled.     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_regfile_sb;

  import core_pkg::*;

  localparam int RB = 5;
  localparam int XL = 64;
  localparam int CW = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [RB-1:0]       rs1_addr, rs2_addr;
  logic [XL-1:0]       rs1_data, rs2_data;
  logic                rs_hazard;
  logic                issue_valid;
  logic [RB-1:0]       issue_rd;
  logic                issue_ok;
  logic [RB-1:0]       wb_rd;
  logic [XL-1:0]       wb_data;
  logic                flush;
  logic                ecall_req;
  logic                ecall_ready;
  logic [7:0][XL-1:0]  ecall_args;

  regfile_sb #(
    .REGBITS (RB),
    .XLEN    (XL),
    .CNTW    (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .rs_hazard   (rs_hazard),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ok    (issue_ok),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .flush       (flush),
    .ecall_req   (ecall_req),
    .ecall_ready (ecall_ready),
    .ecall_args  (ecall_args)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [XL-1:0] val;
  } exp_t;

  exp_t               sb[$];
  logic [8*XL-1:0]    args_q[$];
  int                 n_tests = 0;
  int                 n_fail  = 0;

  task automatic drive_idle();
    rst         = 1'b0;
    rs1_addr    = '0;
    rs2_addr    = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    wb_rd       = '0;
    wb_data     = '0;
    flush       = 1'b0;
    ecall_req   = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  // Runs idle cycles until ecall_ready, optionally with one writeback at cycle wb_at.
  task automatic wait_ready(input int wb_at, input logic [RB-1:0] wrd,
                            input logic [XL-1:0] wdat, output int lat);
    lat = -1;
    for (int k = 1; k <= 12 && lat < 0; k++) begin
      next_cycle();
      if (k == wb_at) begin
        wb_rd   = wrd;
        wb_data = wdat;
      end
      @(negedge clk);
      if (ecall_ready) lat = k;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    next_cycle();
    rs1_addr = 5'd5;
    rs2_addr = 5'd0;
    sb.push_back('{"reset_rs1_x5", 64'h0});
    sb.push_back('{"reset_rs2_x0", 64'h0});
    @(negedge clk);
    e = sb.pop_front(); n_tests++;
    if (rs1_data !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, rs1_data, e.val); end
    e = sb.pop_front(); n_tests++;
    if (rs2_data !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, rs2_data, e.val); end
    n_tests++;
    if (rs_hazard !== 1'b0 || ecall_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: hazard=%b ready=%b want 0/0", rs_hazard, ecall_ready);
    end
    n_tests++;
    if (ecall_args !== '0) begin n_fail++; $display("FAIL reset_args: got %h want 0", ecall_args); end

    // Writeback bubble to x0 must neither bypass nor write.
    next_cycle();
    wb_rd = 5'd0; wb_data = 64'hDEAD; rs1_addr = 5'd0;
    sb.push_back('{"x0_bubble_bypass", 64'h0});
    @(negedge clk);
    e = sb.pop_front(); n_tests++;
    if (rs1_data !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, rs1_data, e.val); end
    next_cycle();
    rs2_addr = 5'd0;
    sb.push_back('{"x0_after_bubble", 64'h0});
    @(negedge clk);
    e = sb.pop_front(); n_tests++;
    if (rs2_data !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, rs2_data, e.val); end
  endtask

  task automatic test_hazard_bypass();
    exp_t e;
    next_cycle();
    issue_valid = 1'b1; issue_rd = 5'd5;
    sb.push_back('{"issue_x5_ok", 64'h1});
    @(negedge clk);
    e = sb.pop_front(); n_tests++;
    if ({63'b0, issue_ok} !== e.val) begin n_fail++; $display("FAIL %s: got %b want %0h", e.name, issue_ok, e.val); end

    next_cycle();
    rs1_addr = 5'd5; issue_valid = 1'b1; issue_rd = 5'd9;
    sb.push_back('{"hazard_x5", 64'h1});
    sb.push_back('{"issue_blocked_x5", 64'h0});
    @(negedge clk);
    e = sb.pop_front(); n_tests++;
    if ({63'b0, rs_hazard} !== e.val) begin n_fail++; $display("FAIL %s: got %b want %0h", e.name, rs_hazard, e.val); end
    e = sb.pop_front(); n_tests++;
    if ({63'b0, issue_ok} !== e.val) begin n_fail++; $display("FAIL %s: got %b want %0h", e.name, issue_ok, e.val); end

    next_cycle();
    rs1_addr = 5'd5; rs2_addr = 5'd5; wb_rd = 5'd5; wb_data = 64'h1234;
    sb.push_back('{"bypass_rs1_x5", 64'h1234});
    sb.push_back('{"bypass_rs2_x5", 64'h1234});
    sb.push_back('{"hazard_clear_on_wb", 64'h0});
    @(negedge clk);
    e = sb.pop_front(); n_tests++;
    if (rs1_data !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, rs1_data, e.val); end
    e = sb.pop_front(); n_tests++;
    if (rs2_data !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, rs2_data, e.val); end
    e = sb.pop_front(); n_tests++;
    if ({63'b0, rs_hazard} !== e.val) begin n_fail++; $display("FAIL %s: got %b want %0h", e.name, rs_hazard, e.val); end

    next_cycle();
    rs1_addr = 5'd5;
    sb.push_back('{"array_x5", 64'h1234});
    @(negedge clk);
    e = sb.pop_front(); n_tests++;
    if (rs1_data !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, rs1_data, e.val); end
  endtask

  task automatic test_saturate();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      issue_valid = 1'b1; issue_rd = 5'd7;
      sb.push_back('{$sformatf("issue_x7_%0d", i), 64'h1});
      @(negedge clk);
      e = sb.pop_front(); n_tests++;
      if ({63'b0, issue_ok} !== e.val) begin n_fail++; $display("FAIL %s: got %b want %0h", e.name, issue_ok, e.val); end
    end
    next_cycle();
    issue_valid = 1'b1; issue_rd = 5'd7;
    sb.push_back('{"issue_x7_saturated", 64'h0});
    @(negedge clk);
    e = sb.pop_front(); n_tests++;
    if ({63'b0, issue_ok} !== e.val) begin n_fail++; $display("FAIL %s: got %b want %0h", e.name, issue_ok, e.val); end

    next_cycle();
    issue_valid = 1'b1; issue_rd = 5'd7; wb_rd = 5'd7; wb_data = 64'h77;
    sb.push_back('{"issue_x7_with_wb", 64'h1});
    @(negedge clk);
    e = sb.pop_front(); n_tests++;
    if ({63'b0, issue_ok} !== e.val) begin n_fail++; $display("FAIL %s: got %b want %0h", e.name, issue_ok, e.val); end

    next_cycle();
    issue_valid = 1'b1; issue_rd = 5'd7;
    sb.push_back('{"x7_still_saturated", 64'h0});
    @(negedge clk);
    e = sb.pop_front(); n_tests++;
    if ({63'b0, issue_ok} !== e.val) begin n_fail++; $display("FAIL %s: got %b want %0h", e.name, issue_ok, e.val); end

    // Retire two of the three pending writes; one remains.
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      wb_rd = 5'd7; wb_data = 64'h70 + 64'(i);
    end
    next_cycle();
    rs1_addr = 5'd7;
    sb.push_back('{"x7_one_pending", 64'h1});
    @(negedge clk);
    e = sb.pop_front(); n_tests++;
    if ({63'b0, rs_hazard} !== e.val) begin n_fail++; $display("FAIL %s: got %b want %0h", e.name, rs_hazard, e.val); end

    next_cycle();
    rs1_addr = 5'd7; wb_rd = 5'd7; wb_data = 64'h7F;
    sb.push_back('{"x7_last_retire_hazard", 64'h0});
    sb.push_back('{"x7_last_retire_data", 64'h7F});
    @(negedge clk);
    e = sb.pop_front(); n_tests++;
    if ({63'b0, rs_hazard} !== e.val) begin n_fail++; $display("FAIL %s: got %b want %0h", e.name, rs_hazard, e.val); end
    e = sb.pop_front(); n_tests++;
    if (rs1_data !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, rs1_data, e.val); end
  endtask

  task automatic test_ecall();
    int              lat;
    logic [8*XL-1:0] exp_args;
    logic [7:0][XL-1:0] a;
    // x10 holds a known value; x12 has one pending write.
    next_cycle();
    wb_rd = 5'd10; wb_data = 64'hA0;
    next_cycle();
    issue_valid = 1'b1; issue_rd = 5'd12;
    next_cycle();
    ecall_req = 1'b1;
    a = '0; a[0] = 64'hA0; a[2] = 64'h42;
    args_q.push_back(a);
    wait_ready(3, 5'd12, 64'h42, lat);
    n_tests++;
    if (lat != 4) begin n_fail++; $display("FAIL ecall_latency_pending: got %0d want 4", lat); end
    exp_args = args_q.pop_front(); n_tests++;
    if (ecall_args !== exp_args) begin n_fail++; $display("FAIL ecall_args_pending: got %h want %h", ecall_args, exp_args); end
    next_cycle();
    @(negedge clk);
    n_tests++;
    if (ecall_ready !== 1'b0) begin n_fail++; $display("FAIL ecall_ready_one_cycle: got %b want 0", ecall_ready); end

    // Nothing pending: minimum latency, new x13 value appears.
    next_cycle();
    wb_rd = 5'd13; wb_data = 64'h1313;
    next_cycle();
    ecall_req = 1'b1;
    a[3] = 64'h1313;
    args_q.push_back(a);
    wait_ready(0, 5'd0, 64'h0, lat);
    n_tests++;
    if (lat != 2) begin n_fail++; $display("FAIL ecall_latency_min: got %0d want 2", lat); end
    exp_args = args_q.pop_front(); n_tests++;
    if (ecall_args !== exp_args) begin n_fail++; $display("FAIL ecall_args_min: got %h want %h", ecall_args, exp_args); end
    // Held after the pulse.
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_tests++;
    if (ecall_args !== exp_args) begin n_fail++; $display("FAIL ecall_args_held: got %h want %h", ecall_args, exp_args); end
  endtask

  task automatic test_flush();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      issue_valid = 1'b1; issue_rd = 5'd3;
    end
    next_cycle();
    flush = 1'b1; wb_rd = 5'd3; wb_data = 64'h9; rs1_addr = 5'd3;
    issue_valid = 1'b1; issue_rd = 5'd4;
    sb.push_back('{"x3_busy_before_flush", 64'h1});
    @(negedge clk);
    e = sb.pop_front(); n_tests++;
    if ({63'b0, rs_hazard} !== e.val) begin n_fail++; $display("FAIL %s: got %b want %0h", e.name, rs_hazard, e.val); end

    next_cycle();
    rs1_addr = 5'd3; rs2_addr = 5'd4;
    sb.push_back('{"flush_hazard_cleared", 64'h0});
    sb.push_back('{"flush_wb_written_x3", 64'h9});
    @(negedge clk);
    e = sb.pop_front(); n_tests++;
    if ({63'b0, rs_hazard} !== e.val) begin n_fail++; $display("FAIL %s: got %b want %0h", e.name, rs_hazard, e.val); end
    e = sb.pop_front(); n_tests++;
    if (rs1_data !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, rs1_data, e.val); end
  endtask

  task automatic test_reset_mid_drain();
    int seen;
    next_cycle();
    issue_valid = 1'b1; issue_rd = 5'd15;
    next_cycle();
    ecall_req = 1'b1;
    next_cycle();
    rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      @(negedge clk);
      if (ecall_ready !== 1'b0) seen++;
    end
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL reset_abort_ready: got %0d pulses want 0", seen); end
    next_cycle();
    rs1_addr = 5'd15; rs2_addr = 5'd10;
    @(negedge clk);
    n_tests++;
    if (rs_hazard !== 1'b0 || rs1_data !== 64'h0 || rs2_data !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_abort_regs: hazard=%b x15=%h x10=%h want 0/0/0", rs_hazard, rs1_data, rs2_data);
    end
    n_tests++;
    if (ecall_args !== '0) begin n_fail++; $display("FAIL reset_abort_args: got %h want 0", ecall_args); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    drive_idle();
    rst = 1'b1;
    test_reset();
    test_hazard_bypass();
    test_saturate();
    test_ecall();
    test_flush();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
